// File: rtl/line_buffer_if.sv
// rtl/line_buffer_if.sv - pixel stream in / pixel column out bundle for line_buffer
interface line_buffer_if #(
   parameter int HEIGHT_NB = 3,
   parameter int IMG_WIDTH = 8
);
   logic [IMG_WIDTH-1:0]           up_img;
   logic                           up_val;
   logic                           up_eof;
   logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img;
   logic                           dn_val;

   modport master (
      output up_img, up_val, up_eof,
      input  dn_img, dn_val
   );

   modport slave (
      input  up_img, up_val, up_eof,
      output dn_img, dn_val
   );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - raster pixel stream to HEIGHT_NB-tall column using line memories
// Optional top-of-frame zero padding when LINE_BUFFER_PAD_EN is defined.
module line_buffer #(
   parameter int HEIGHT_NB = 3,
   parameter int IMG_WIDTH = 8,
   parameter int LINE_NB   = 640
) (
   input logic        clk,
   input logic        rst,
   line_buffer_if.slave bus
);
   localparam int AW = $clog2(LINE_NB);
   localparam int RW = (HEIGHT_NB > 2) ? $clog2(HEIGHT_NB) : 1;
   localparam logic [AW-1:0] COL_LAST = AW'(LINE_NB - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_NB - 1);

   logic [AW-1:0] col;
   logic [RW-1:0] row;
   logic          accept;
   logic          primed;
   logic          out_en;

   logic [IMG_WIDTH-1:0]           mem [HEIGHT_NB-1][LINE_NB];
   logic [HEIGHT_NB*IMG_WIDTH-1:0] col_data;
   logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img_q;
   logic                           dn_val_q;

   assign accept = bus.up_val;
   assign primed = (row == ROW_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (bus.up_eof) begin
            col <= '0;
            row <= '0;
         end else if (col == COL_LAST) begin
            col <= '0;
            if (!primed)
               row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Each memory takes the row above it; reads below see pre-write contents.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < HEIGHT_NB - 2; k++)
            mem[k][col] <= mem[k+1][col];
         mem[HEIGHT_NB-2][col] <= bus.up_img;
      end
   end

   always_comb begin
      col_data = '0;
      for (int h = 0; h < HEIGHT_NB - 1; h++) begin
         col_data[h*IMG_WIDTH +: IMG_WIDTH] = mem[h][col];
`ifdef LINE_BUFFER_PAD_EN
         if (h < HEIGHT_NB - 1 - int'(row))
            col_data[h*IMG_WIDTH +: IMG_WIDTH] = '0;
`endif
      end
      col_data[(HEIGHT_NB-1)*IMG_WIDTH +: IMG_WIDTH] = bus.up_img;
   end

`ifdef LINE_BUFFER_PAD_EN
   assign out_en = accept;
`else
   assign out_en = accept & primed;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         dn_val_q <= 1'b0;
         dn_img_q <= '0;
      end else begin
         dn_val_q <= out_en;
         if (out_en)
            dn_img_q <= col_data;
      end
   end

   assign bus.dn_val = dn_val_q;
   assign bus.dn_img = dn_img_q;
endmodule

// File: tb/tb_line_buffer.sv
// tb/tb_line_buffer.sv - randomized and directed checks of line_buffer against a frame model
module tb_line_buffer;
   localparam int H  = 3;
   localparam int W  = 8;
   localparam int LN = 4;
   localparam int FB = 1024;

`ifdef LINE_BUFFER_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   line_buffer_if #(.HEIGHT_NB(H), .IMG_WIDTH(W)) bus ();
   line_buffer #(.HEIGHT_NB(H), .IMG_WIDTH(W), .LINE_NB(LN)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int compared = 0;
   int mismatched = 0;

   // Model: pixels of the current frame indexed by beat number within the frame.
   logic [W-1:0]   frame_pix [FB];
   int             n = 0;
   logic           exp_val;
   logic [H*W-1:0] exp_img;
   logic [H*W-1:0] last_img = '0;
   logic           img_known = 1'b1;
   logic           obs_val;
   logic [H*W-1:0] obs_img;

   task automatic model_beat(input logic [W-1:0] pix, input logic eof);
      int r;
      int idx;
      r = n / LN;
      frame_pix[n % FB] = pix;
      exp_val = PAD || (r >= H - 1);
      exp_img = '0;
      for (int h = 0; h < H; h++) begin
         idx = n - (H - 1 - h) * LN;
         if (idx >= 0)
            exp_img[h*W +: W] = frame_pix[idx % FB];
      end
      if (exp_val) begin
         last_img = exp_img;
         img_known = 1'b1;
      end else begin
         img_known = 1'b0;
      end
      n = eof ? 0 : n + 1;
   endtask

   task automatic drive_beat(input logic [W-1:0] pix, input logic eof);
      bus.up_img = pix;
      bus.up_val = 1'b1;
      bus.up_eof = eof;
      model_beat(pix, eof);
      @(posedge clk); #1;
      bus.up_val = 1'b0;
      bus.up_eof = 1'b0;
      obs_val = bus.dn_val;
      obs_img = bus.dn_img;
   endtask

   task automatic drive_idle(input logic eof);
      bus.up_eof = eof;
      exp_val = 1'b0;
      @(posedge clk); #1;
      bus.up_eof = 1'b0;
      obs_val = bus.dn_val;
      obs_img = bus.dn_img;
   endtask

   task automatic test_reset();
      bus.up_img = '0;
      bus.up_val = 1'b0;
      bus.up_eof = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n = 0; last_img = '0; img_known = 1'b1;
      compared++;
      if (bus.dn_val !== 1'b0 || bus.dn_img !== '0) begin
         mismatched++;
         $display("FAIL reset: dn_val=%0b dn_img=%h required 0/0", bus.dn_val, bus.dn_img);
      end
   endtask

   task automatic test_prime();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < LN; c++) begin
            drive_beat(W'(r * 16 + c), 1'b0);
            compared++;
            if (obs_val !== exp_val || (exp_val && obs_img !== exp_img)) begin
               mismatched++;
               $display("FAIL prime r%0d c%0d: dn_val=%0b dn_img=%h required %0b/%h",
                        r, c, obs_val, obs_img, exp_val, exp_img);
            end
         end
   endtask

   task automatic test_gaps();
      int seen = 0;
      int want = 0;
      for (int c = 0; c < LN; c++) begin
         drive_beat(W'(3 * 16 + c), 1'b0);
         want += int'(exp_val);
         seen += int'(obs_val);
         compared++;
         if (obs_val !== exp_val || (exp_val && obs_img !== exp_img)) begin
            mismatched++;
            $display("FAIL gaps beat c%0d: dn_val=%0b dn_img=%h required %0b/%h",
                     c, obs_val, obs_img, exp_val, exp_img);
         end
         for (int g = 0; g < 3; g++) begin
            drive_idle(1'b0);
            seen += int'(obs_val);
            compared++;
            if (obs_val !== 1'b0 || (img_known && obs_img !== last_img)) begin
               mismatched++;
               $display("FAIL gaps hold c%0d g%0d: dn_val=%0b dn_img=%h required 0/%h",
                        c, g, obs_val, obs_img, last_img);
            end
         end
      end
      compared++;
      if (seen !== want) begin
         mismatched++;
         $display("FAIL gaps valid count: saw %0d required %0d", seen, want);
      end
   endtask

   task automatic test_steady_eof();
      for (int r = 4; r < 6; r++)
         for (int c = 0; c < LN; c++) begin
            drive_beat(W'(r * 16 + c), (r == 5 && c == LN - 1));
            compared++;
            if (obs_val !== exp_val || (exp_val && obs_img !== exp_img)) begin
               mismatched++;
               $display("FAIL steady/eof r%0d c%0d: dn_val=%0b dn_img=%h required %0b/%h",
                        r, c, obs_val, obs_img, exp_val, exp_img);
            end
         end
      for (int b = 0; b < 9; b++) begin
         drive_beat(W'($urandom), 1'b0);
         compared++;
         if (obs_val !== exp_val || (exp_val && obs_img !== exp_img)) begin
            mismatched++;
            $display("FAIL reprime beat %0d: dn_val=%0b dn_img=%h required %0b/%h",
                     b, obs_val, obs_img, exp_val, exp_img);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive_beat(W'($urandom), 1'b1);
      for (int b = 0; b < 2 * LN + 2; b++)
         drive_beat(W'($urandom), 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0; last_img = '0; img_known = 1'b1;
      compared++;
      if (bus.dn_val !== 1'b0 || bus.dn_img !== '0) begin
         mismatched++;
         $display("FAIL reset mid-line: dn_val=%0b dn_img=%h required 0/0", bus.dn_val, bus.dn_img);
      end
      for (int b = 0; b < 2 * LN + 2; b++) begin
         drive_beat(W'($urandom), 1'b0);
         if (b == 1) begin
            drive_idle(1'b1);
            compared++;
            if (obs_val !== 1'b0 || (img_known && obs_img !== last_img)) begin
               mismatched++;
               $display("FAIL eof without val: dn_val=%0b dn_img=%h required 0/%h",
                        obs_val, obs_img, last_img);
            end
         end
         compared++;
         if (obs_val !== exp_val || (exp_val && obs_img !== exp_img)) begin
            mismatched++;
            $display("FAIL restart beat %0d: dn_val=%0b dn_img=%h required %0b/%h",
                     b, obs_val, obs_img, exp_val, exp_img);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            drive_idle(1'($urandom_range(0, 1)));
            compared++;
            if (obs_val !== 1'b0 || (img_known && obs_img !== last_img)) begin
               mismatched++;
               $display("FAIL random idle %0d: dn_val=%0b dn_img=%h required 0/%h",
                        i, obs_val, obs_img, last_img);
            end
         end
         drive_beat(W'($urandom), ($urandom_range(0, 19) == 0));
         compared++;
         if (obs_val !== exp_val || (exp_val && obs_img !== exp_img)) begin
            mismatched++;
            $display("FAIL random beat %0d: dn_val=%0b dn_img=%h required %0b/%h",
                     i, obs_val, obs_img, exp_val, exp_img);
         end
      end
   endtask

   initial begin
      test_reset();
      test_prime();
      test_gaps();
      test_steady_eof();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
